nco_sweep_controller: RTL and testbench
=======================================

Name: nco_sweep_controller

Overview:
- Sequences the frequency tuning word (increment) fed to the NCO phase accumulator.
- Accepts a sweep configuration (start, stop, step, dwell, mode) over a valid/ready handshake.
- On a start command, steps the increment from start toward stop. Each value is held for a programmable number of clocks.
- Supports single-shot, repeating sawtooth and triangle sweeps, and pulses an accumulator clear at sweep launch.

Parameters:
- WIDTH, 26, width of tuning word; matches the phase accumulator width.
- DWELL_W, 16, width of the dwell counter.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration can be accepted; high only in IDLE.
- cfg_start  in  WIDTH  first tuning word.
- cfg_stop  in  WIDTH  endpoint tuning word.
- cfg_step  in  WIDTH  magnitude of the per-step change.
- cfg_dwell  in  DWELL_W  hold time; each value is held cfg_dwell+1 cycles.
- cfg_mode  in  2  0 = single, 1 = sawtooth repeat, 2 = triangle, 3 = reserved (treated as single).
- start  in  1  launch the sweep; honoured in IDLE only.
- abort  in  1  terminate the sweep.
- increment  out  WIDTH  registered tuning word to the phase accumulator.
- acc_clear  out  1  registered one-cycle pulse to clear accumulator phase.
- busy  out  1  high in LOAD or SWEEP.
- done  out  1  one-cycle pulse at completion of a single-mode sweep.
- dir_down  out  1  current sweep direction; 1 = decreasing.

Behaviour:
- Reset state (reset_n low at a clk edge):
  - state = IDLE, increment = 0, acc_clear = 0, busy = 0, done = 0, dir_down = 0.
  - Config registers = 0. cfg_ready = 1 after reset.
- Handshake: config is captured on any edge with cfg_valid && cfg_ready. Config offered outside IDLE is not accepted and remains pending.
- Simultaneous cfg accept and start in IDLE: the sweep uses the newly captured config.
- States:
  - IDLE --start--> LOAD. acc_clear <= 1.
  - LOAD --> SWEEP on the next edge:
    - increment <= cfg_start; acc_clear <= 0; dwell_cnt <= cfg_dwell.
    - dir_down <= (cfg_start > cfg_stop).
  - SWEEP: if dwell_cnt != 0, decrement it. If dwell_cnt == 0, apply the step rule and reload dwell_cnt <= cfg_dwell.
- Latency:
  - increment equals cfg_start from 2 cycles after start is sampled.
  - acc_clear is high during exactly the cycle following the start sample.
  - Every tuning value is held exactly cfg_dwell+1 cycles.
- Step rule, computed in WIDTH+1 bits with no wrap:
  - Up: nxt = increment + step. If nxt >= stop, set increment = stop and flag endpoint; else increment = nxt.
  - Down: if increment <= stop + step, set increment = stop and flag endpoint; else increment = increment - step.
- Endpoint handling (applied on the dwell expiry of the stop value itself):
  - Single: done <= 1 for one cycle; state goes to IDLE; increment holds stop.
  - Sawtooth: increment <= cfg_start; no acc_clear, so phase stays continuous.
  - Triangle: dir_down toggles and stepping continues toward cfg_start, which then acts as the endpoint. Each turnaround value is held once, not twice.
- Boundaries:
  - step == 0: increment holds cfg_start indefinitely; no done; only abort exits.
  - start == stop: the first dwell expiry is the endpoint. Single mode then completes; sawtooth and triangle hold the value indefinitely.
- abort: highest priority in any state. The next edge sets state = IDLE, increment = 0, busy = 0, done = 0, and acc_clear = 0. abort together with start in IDLE means start is ignored.
- Reset mid-sweep returns to full reset values on the next edge.

Decomposition:
- Package nco_pkg:
  - sweep_state_t enum {IDLE, LOAD, SWEEP}.
  - sweep_mode_t enum {SINGLE, SAWTOOTH, TRIANGLE}.
  - Shared NCO_WIDTH default constant.
- Sub-module nco_dwell_timer: a loadable down-counter with zero flag and synchronous clear.

Test Plan:
- Single up sweep, start=100, stop=130, step=10, dwell=2 -> increment 100, 110, 120, 130, each held 3 cycles. done pulses 3 cycles after 130 appears, then busy = 0 and increment stays 130.
- Up saturation, step=20 with the same config -> sequence 100, 120, 130; done asserted once.
- Down sweep, start=130, stop=100, step=10, dwell=0 -> dir_down = 1; increment 130, 120, 110, 100, one cycle each; then done.
- Triangle, start=100, stop=120, step=10, dwell=0 -> 100, 110, 120, 110, 100, 110, …; dir_down toggles at 120 and 100; acc_clear only once, at launch.
- Abort during the 110 dwell -> next cycle increment = 0, busy = 0, cfg_ready = 1, no done. A config offered while busy is not accepted until IDLE.
- reset_n low mid-sweep for 1 cycle -> all outputs at reset values. start with step=0 -> increment holds 100 indefinitely until abort.

Source files
------------

// File: rtl/nco_pkg.sv
// Shared types and default widths for the NCO sweep controller.
package nco_pkg;

    localparam int NCO_WIDTH   = 26;
    localparam int DWELL_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2
    } sweep_state_t;

    // Mode code 3 is reserved and behaves as SINGLE.
    typedef enum logic [1:0] {
        SINGLE   = 2'd0,
        SAWTOOTH = 2'd1,
        TRIANGLE = 2'd2
    } sweep_mode_t;

endpackage

// File: rtl/nco_dwell_timer.sv
// Loadable dwell down-counter; zero flags terminal count.
module nco_dwell_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/nco_sweep_controller.sv
// Steps the NCO tuning word from start toward stop, holding each value
// for dwell+1 clocks, in single, sawtooth or triangle mode.
//
// state | meaning
// IDLE  | waiting for start; configuration accepted here only
// LOAD  | accumulator clear pulse; first tuning word and dwell loaded next
// SWEEP | holding/stepping the tuning word
module nco_sweep_controller
    import nco_pkg::*;
#(
    parameter int WIDTH   = NCO_WIDTH,
    parameter int DWELL_W = DWELL_WIDTH
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [WIDTH-1:0]   cfg_start,
    input  logic [WIDTH-1:0]   cfg_stop,
    input  logic [WIDTH-1:0]   cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    input  logic               start,
    input  logic               abort,
    output logic [WIDTH-1:0]   increment,
    output logic               acc_clear,
    output logic               busy,
    output logic               done,
    output logic               dir_down
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_LOAD  = LOAD;
    localparam logic [1:0] S_SWEEP = SWEEP;

    logic [1:0]         state;
    logic [WIDTH-1:0]   start_q, stop_q, step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [1:0]         mode_q;
    logic               at_end, to_stop;
    logic               dwell_zero, dwell_load;
    logic [WIDTH-1:0]   target, turn_target;
    logic [WIDTH:0]     step_res, turn_res;

    // Returns {endpoint, next value}; the extra bit keeps the sum from wrapping.
    function automatic logic [WIDTH:0] step_next(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] tgt,
                                                 input logic [WIDTH-1:0] stp,
                                                 input logic             down);
        logic [WIDTH:0] sum;
        logic [WIDTH:0] lim;
        sum = {1'b0, cur} + {1'b0, stp};
        lim = {1'b0, tgt} + {1'b0, stp};
        if (!down) begin
            step_next = (sum >= {1'b0, tgt}) ? {1'b1, tgt} : {1'b0, sum[WIDTH-1:0]};
        end else begin
            step_next = ({1'b0, cur} <= lim) ? {1'b1, tgt} : {1'b0, cur - stp};
        end
    endfunction

    assign cfg_ready   = (state == S_IDLE);
    assign busy        = (state == S_LOAD) || (state == S_SWEEP);
    assign target      = to_stop ? stop_q : start_q;
    assign turn_target = to_stop ? start_q : stop_q;
    assign step_res    = step_next(increment, target, step_q, dir_down);
    assign turn_res    = step_next(increment, turn_target, step_q, ~dir_down);
    assign dwell_load  = (state == S_LOAD) || ((state == S_SWEEP) && dwell_zero);

    nco_dwell_timer #(.WIDTH(DWELL_W)) u_dwell (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (abort),
        .load       (dwell_load),
        .load_value (dwell_q),
        .zero       (dwell_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            mode_q  <= '0;
        end else if (cfg_valid && cfg_ready) begin
            start_q <= cfg_start;
            stop_q  <= cfg_stop;
            step_q  <= cfg_step;
            dwell_q <= cfg_dwell;
            mode_q  <= cfg_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            increment <= '0;
            acc_clear <= 1'b0;
            done      <= 1'b0;
            dir_down  <= 1'b0;
            at_end    <= 1'b0;
            to_stop   <= 1'b0;
        end else if (abort) begin
            state     <= S_IDLE;
            increment <= '0;
            acc_clear <= 1'b0;
            done      <= 1'b0;
        end else begin
            acc_clear <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        acc_clear <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state     <= S_SWEEP;
                    increment <= start_q;
                    dir_down  <= (start_q > stop_q);
                    at_end    <= (start_q == stop_q);
                    to_stop   <= 1'b1;
                end
                S_SWEEP: begin
                    if (dwell_zero) begin
                        if (!at_end) begin
                            {at_end, increment} <= step_res;
                        end else if (mode_q == SAWTOOTH) begin
                            // Phase stays continuous: no accumulator clear on wrap.
                            increment <= start_q;
                            at_end    <= (start_q == stop_q);
                        end else if (mode_q == TRIANGLE) begin
                            {at_end, increment} <= turn_res;
                            dir_down  <= ~dir_down;
                            to_stop   <= ~to_stop;
                        end else begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nco_sweep_controller.sv
// Self-checking bench: directed and random sweeps against a value-list model.
module tb_nco_sweep_controller;

    localparam int WIDTH = 26;
    localparam int DW    = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] cfg_start = '0;
    logic [WIDTH-1:0] cfg_stop = '0;
    logic [WIDTH-1:0] cfg_step = '0;
    logic [DW-1:0]    cfg_dwell = '0;
    logic [1:0]       cfg_mode = '0;
    logic             cfg_ready, acc_clear, busy, done, dir_down;
    logic [WIDTH-1:0] increment;

    int checks = 0;
    int failures = 0;

    typedef struct {
        longint st;
        longint sp;
        longint stp;
        int     dw;
        int     md;
    } cfg_t;

    longint exp_val[$];
    bit     exp_dir[$];
    bit     exp_fin;

    nco_sweep_controller dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_start (cfg_start),
        .cfg_stop  (cfg_stop),
        .cfg_step  (cfg_step),
        .cfg_dwell (cfg_dwell),
        .cfg_mode  (cfg_mode),
        .start     (start),
        .abort     (abort),
        .increment (increment),
        .acc_clear (acc_clear),
        .busy      (busy),
        .done      (done),
        .dir_down  (dir_down)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_cfg(input cfg_t c);
        cfg_start = c.st[WIDTH-1:0];
        cfg_stop  = c.sp[WIDTH-1:0];
        cfg_step  = c.stp[WIDTH-1:0];
        cfg_dwell = c.dw[DW-1:0];
        cfg_mode  = c.md[1:0];
    endtask

    function automatic longint move_to(longint v, longint tgt, longint stp, bit down);
        if (down) return (v - tgt <= stp) ? tgt : v - stp;
        return (tgt - v <= stp) ? tgt : v + stp;
    endfunction

    // Ordered list of tuning values (and direction) the sweep should produce.
    task automatic gen(input cfg_t c, input int n);
        longint v, tgt;
        bit down, to_stop;
        exp_val.delete();
        exp_dir.delete();
        exp_fin = 1'b0;
        v = c.st;
        tgt = c.sp;
        down = (c.st > c.sp);
        to_stop = 1'b1;
        exp_val.push_back(v);
        exp_dir.push_back(down);
        while (exp_val.size() < n) begin
            if (v == tgt) begin
                if (c.md == 1) begin
                    v = c.st;
                end else if (c.md == 2) begin
                    down = !down;
                    tgt = to_stop ? c.st : c.sp;
                    to_stop = !to_stop;
                    v = move_to(v, tgt, c.stp, down);
                end else begin
                    exp_fin = 1'b1;
                    break;
                end
            end else begin
                v = move_to(v, tgt, c.stp, down);
            end
            exp_val.push_back(v);
            exp_dir.push_back(down);
        end
    endtask

    // src: 0 = config with start, 1 = config the cycle before, 2 = use held config.
    task automatic run_sweep(input cfg_t c, input int src, input int abort_cyc,
                             input bit pend, input cfg_t pc);
        int cyc;
        bit aborted;
        gen(c, abort_cyc / (c.dw + 1) + 2);
        if (src == 1) begin
            drive_cfg(c);
            cfg_valid = 1'b1;
            check("cfg_ready_idle", cfg_ready, 1);
            tick();
            cfg_valid = 1'b0;
        end else if (src == 0) begin
            drive_cfg(c);
            cfg_valid = 1'b1;
        end
        start = 1'b1;
        check("cfg_ready_before_start", cfg_ready, 1);
        tick();
        start = 1'b0;
        cfg_valid = 1'b0;
        check("acc_clear_launch", acc_clear, 1);
        check("busy_load", busy, 1);
        check("cfg_ready_load", cfg_ready, 0);
        tick();
        cyc = 0;
        aborted = 1'b0;
        foreach (exp_val[i]) begin
            for (int d = 0; d <= c.dw && !aborted; d++) begin
                check("increment", increment, exp_val[i][WIDTH-1:0]);
                check("dir_down", dir_down, exp_dir[i]);
                check("busy_sweep", busy, 1);
                check("done_sweep", done, 0);
                check("acc_clear_sweep", acc_clear, 0);
                check("cfg_ready_sweep", cfg_ready, 0);
                if (pend && cyc == 1) begin
                    drive_cfg(pc);
                    cfg_valid = 1'b1;
                end
                if (cyc == abort_cyc) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    check("abort_increment", increment, 0);
                    check("abort_busy", busy, 0);
                    check("abort_done", done, 0);
                    check("abort_acc_clear", acc_clear, 0);
                    check("abort_cfg_ready", cfg_ready, 1);
                    aborted = 1'b1;
                end else begin
                    tick();
                end
                cyc++;
            end
            if (aborted) break;
        end
        if (!aborted && exp_fin) begin
            check("done_pulse", done, 1);
            check("busy_after_done", busy, 0);
            check("increment_after_done", increment, c.sp[WIDTH-1:0]);
            check("cfg_ready_after_done", cfg_ready, 1);
            tick();
            check("done_one_cycle", done, 0);
            check("increment_holds_stop", increment, c.sp[WIDTH-1:0]);
        end
    endtask

    task automatic check_reset_values();
        check("rst_increment", increment, 0);
        check("rst_acc_clear", acc_clear, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dir_down", dir_down, 0);
        check("rst_cfg_ready", cfg_ready, 1);
    endtask

    initial begin
        cfg_t c, b, z;
        z = '{0, 0, 0, 0, 0};
        reset_n = 1'b0;
        tick();
        tick();
        check_reset_values();
        reset_n = 1'b1;
        tick();

        c = '{100, 130, 10, 2, 0};  run_sweep(c, 1, 200, 0, c);
        c = '{100, 130, 20, 2, 0};  run_sweep(c, 0, 200, 0, c);
        c = '{130, 100, 10, 0, 0};  run_sweep(c, 0, 200, 0, c);
        c = '{100, 120, 10, 0, 2};  run_sweep(c, 0, 15, 0, c);
        c = '{100, 120, 10, 1, 1};  run_sweep(c, 0, 20, 0, c);

        // Abort during the 110 dwell with a config pending; it lands once idle.
        c = '{100, 130, 10, 2, 0};
        b = '{200, 220, 20, 0, 0};
        run_sweep(c, 0, 4, 1, b);
        tick();
        cfg_valid = 1'b0;
        run_sweep(b, 2, 200, 0, b);

        // abort together with start in IDLE: start ignored.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_busy", busy, 0);
        check("abort_start_acc_clear", acc_clear, 0);
        tick();
        check("abort_start_busy_later", busy, 0);

        c = '{100, 130, 0, 1, 0};   run_sweep(c, 0, 20, 0, c);
        c = '{77, 77, 5, 1, 0};     run_sweep(c, 0, 200, 0, c);
        c = '{77, 77, 5, 0, 1};     run_sweep(c, 0, 8, 0, c);
        c = '{77, 77, 5, 0, 2};     run_sweep(c, 0, 8, 0, c);
        c = '{90, 40, 15, 1, 2};    run_sweep(c, 1, 30, 0, c);

        // Reset mid-sweep, then a start with the cleared config.
        c = '{100, 130, 10, 2, 0};
        drive_cfg(c);
        cfg_valid = 1'b1;
        start = 1'b1;
        tick();
        cfg_valid = 1'b0;
        start = 1'b0;
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        check_reset_values();
        reset_n = 1'b1;
        tick();
        run_sweep(z, 2, 50, 0, z);

        for (int k = 0; k < 25; k++) begin
            c.st  = longint'($urandom_range(0, 300));
            c.sp  = longint'($urandom_range(0, 300));
            c.stp = ($urandom_range(0, 7) == 0) ? 0 : longint'($urandom_range(1, 40));
            c.dw  = int'($urandom_range(0, 3));
            c.md  = int'($urandom_range(0, 3));
            run_sweep(c, int'($urandom_range(0, 1)), 60, 0, c);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
